// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - byte FIFO feeding uart_transimitter one byte at a time
// The head byte is only popped once the transmitter reports completion, so a lost write is retried.
module uart_tx_feeder #(
  parameter int DEPTH        = 4,
  parameter int ADDR_W       = 2,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        wr_data,
  input  logic              wr_en,
  input  logic              tx_enable,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              feeder_busy,
  output logic [7:0]        Tx_Data,
  output logic              Tx_WR,
  input  logic              Tx_BUSY
);

  typedef enum logic [1:0] {IDLE, PULSE, WAIT_BUSY, WAIT_DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_C      = (ADDR_W+1)'(DEPTH);
  localparam logic [7:0]      TIMEOUT_LAST = 8'(BUSY_TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [7:0]          mem_q [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]     count_q, count_d;
  logic                overflow_q;
  logic [7:0]          timer_q, timer_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_wr_q, tx_wr_d;
  logic                push, pop;

  assign full        = (count_q == DEPTH_C);
  assign empty       = (count_q == '0);
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign feeder_busy = (state_q != IDLE);
  assign Tx_Data     = tx_data_q;
  assign Tx_WR       = tx_wr_q;

  // A write into a full FIFO is dropped even when a pop frees a slot on the same edge.
  assign push = wr_en && !full;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    tx_data_d = tx_data_q;
    tx_wr_d   = 1'b0;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_enable && !empty) begin
          tx_data_d = mem_q[rd_ptr_q];
          tx_wr_d   = 1'b1;
          state_d   = PULSE;
        end
      end
      PULSE: begin
        timer_d = 8'd0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (Tx_BUSY) begin
          state_d = WAIT_DONE;
        end else begin
          timer_d = timer_q + 8'd1;
          if (timer_d == TIMEOUT_LAST) state_d = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!Tx_BUSY) begin
          pop     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      timer_q    <= 8'd0;
      tx_data_q  <= 8'd0;
      tx_wr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      timer_q   <= timer_d;
      tx_data_q <= tx_data_d;
      tx_wr_q   <= tx_wr_d;
      if (push)        wr_ptr_q   <= wr_ptr_q + 1'b1;
      if (pop)         rd_ptr_q   <= rd_ptr_q + 1'b1;
      if (wr_en && full) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - randomized and directed checks of uart_tx_feeder against a queue model
module tb_uart_tx_feeder;
  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 2;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [7:0]       wr_data = 8'd0;
  logic             wr_en = 1'b0;
  logic             tx_enable = 1'b0;
  logic             Tx_BUSY = 1'b0;
  logic             full, empty, overflow, feeder_busy, Tx_WR;
  logic [ADDR_W:0]  count;
  logic [7:0]       Tx_Data;

  always #5 clk = ~clk;

  uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BUSY_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_en(wr_en), .tx_enable(tx_enable),
    .full(full), .empty(empty), .count(count), .overflow(overflow), .feeder_busy(feeder_busy),
    .Tx_Data(Tx_Data), .Tx_WR(Tx_WR), .Tx_BUSY(Tx_BUSY)
  );

  // Transmitter stand-in: busy some cycles after each write pulse, optionally ignoring pulses.
  int ncyc = 0, b_start = 0, b_end = 0;
  int ignore_req = 0, ign_used = 0;
  int fix_delay = 1, fix_hold = 3;
  bit rand_mode = 1'b0;

  always @(negedge clk) begin
    bit drop;
    ncyc++;
    if (!reset) begin
      b_start = 0;
      b_end   = 0;
    end else if (Tx_WR) begin
      drop = rand_mode && ($urandom_range(0, 7) == 0);
      if (ign_used < ignore_req) ign_used++;
      else if (!drop) begin
        b_start = ncyc + (rand_mode ? int'($urandom_range(1, 3)) : fix_delay);
        b_end   = b_start + (rand_mode ? int'($urandom_range(1, 6)) : fix_hold);
      end
    end
    Tx_BUSY = reset && (ncyc >= b_start) && (ncyc < b_end);
  end

  // Reference model: FIFO contents as a queue, the byte in flight as a few flags/counters.
  logic [7:0] mq[$];
  bit         m_ovf, m_active, m_seen, m_wr;
  int         m_since;
  logic [7:0] m_data;

  int n_vec = 0, n_err = 0, ecnt = 0;
  logic [7:0] log_q[$];
  int         ptime[$];

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_active = 0; m_seen = 0; m_wr = 0; m_since = 0; m_data = 8'd0;
  endtask

  task automatic model_step(input bit we, input logic [7:0] wd, input bit en, input bit bz);
    bit full_pre, do_pop;
    full_pre = (mq.size() == DEPTH);
    do_pop   = 0;
    m_wr     = 0;
    if (!m_active) begin
      if (en && mq.size() > 0) begin
        m_active = 1; m_seen = 0; m_since = 0; m_data = mq[0]; m_wr = 1;
      end
    end else if (!m_seen) begin
      if (m_since == 0)                m_since = 1;
      else if (bz)                     m_seen = 1;
      else if (m_since == TIMEOUT - 1) m_active = 0;
      else                             m_since++;
    end else if (!bz) begin
      do_pop   = 1;
      m_active = 0;
    end
    if (do_pop) void'(mq.pop_front());
    if (we) begin
      if (full_pre) m_ovf = 1;
      else          mq.push_back(wd);
    end
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  // One clock: model advances at the edge, DUT compared on the falling edge.
  task automatic tick();
    logic [15:0] got, exp;
    @(posedge clk);
    if (!reset) model_reset();
    else        model_step(wr_en, wr_data, tx_enable, Tx_BUSY);
    @(negedge clk);
    ecnt++;
    if (reset) begin
      got = {Tx_WR, Tx_Data, full, empty, count, overflow, feeder_busy};
      exp = {m_wr, m_data, (mq.size() == DEPTH), (mq.size() == 0), 3'(mq.size()), m_ovf, m_active};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL cycle %0d: got wr=%0b data=%02h full=%0b empty=%0b count=%0d ovf=%0b busy=%0b, expected wr=%0b data=%02h full=%0b empty=%0b count=%0d ovf=%0b busy=%0b",
                 ecnt, got[15], got[14:7], got[6], got[5], got[4:2], got[1], got[0],
                 exp[15], exp[14:7], exp[6], exp[5], exp[4:2], exp[1], exp[0]);
      end
      if (Tx_WR === 1'b1) begin
        log_q.push_back(Tx_Data);
        ptime.push_back(ecnt);
      end
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int k = 0;
    while (!(empty === 1'b1 && feeder_busy === 1'b0) && k < budget) begin
      tick();
      k++;
    end
    check({nm, "_in_time"}, 32'(k < budget), 32'd1);
  endtask

  task automatic check_reset_values(input string nm);
    check({nm, "_Tx_Data"}, 32'(Tx_Data), 32'h0);
    check({nm, "_Tx_WR"}, 32'(Tx_WR), 32'h0);
    check({nm, "_full"}, 32'(full), 32'h0);
    check({nm, "_empty"}, 32'(empty), 32'h1);
    check({nm, "_count"}, 32'(count), 32'h0);
    check({nm, "_overflow"}, 32'(overflow), 32'h0);
    check({nm, "_feeder_busy"}, 32'(feeder_busy), 32'h0);
  endtask

  initial begin
    int base, k;
    repeat (3) tick();
    check_reset_values("reset");
    reset = 1'b1;

    // Word split: 0xA5 then 0x3C, long transmitter busy.
    fix_delay = 2; fix_hold = 100; tx_enable = 1'b1;
    base = log_q.size();
    push_byte(8'hA5);
    push_byte(8'h3C);
    wait_idle(400, "word_split");
    check("word_pulses", 32'(log_q.size() - base), 32'd2);
    check("word_byte0", 32'(log_q[base]), 32'hA5);
    check("word_byte1", 32'(log_q[base + 1]), 32'h3C);
    check("word_count", 32'(count), 32'd0);

    // Timeout retry: first pulse of 0x77 is ignored.
    fix_delay = 1; fix_hold = 3;
    ignore_req++;
    base = log_q.size();
    push_byte(8'h77);
    wait_idle(200, "retry");
    check("retry_pulses", 32'(log_q.size() - base), 32'd2);
    check("retry_byte0", 32'(log_q[base]), 32'h77);
    check("retry_byte1", 32'(log_q[base + 1]), 32'h77);
    check("retry_gap", 32'(ptime[base + 1] - ptime[base]), 32'(TIMEOUT + 1));
    check("retry_count", 32'(count), 32'd0);

    // Pointer wrap: one push per completed byte.
    base = log_q.size();
    for (int i = 0; i < 10; i++) begin
      push_byte(8'h10 + 8'(i));
      wait_idle(100, "wrap");
    end
    check("wrap_pulses", 32'(log_q.size() - base), 32'd10);
    for (int i = 0; i < 10; i++) check("wrap_order", 32'(log_q[base + i]), 32'(8'h10 + 8'(i)));
    check("wrap_overflow", 32'(overflow), 32'd0);

    // Overflow: five pushes while disabled.
    tx_enable = 1'b0;
    for (int i = 1; i <= 5; i++) push_byte(8'(i));
    check("ovf_count", 32'(count), 32'd4);
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_flag", 32'(overflow), 32'd1);
    base = log_q.size();
    tx_enable = 1'b1;
    wait_idle(200, "ovf_drain");
    check("ovf_pulses", 32'(log_q.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) check("ovf_order", 32'(log_q[base + i]), 32'(i + 1));

    // Reset mid-byte with three bytes queued.
    tx_enable = 1'b0;
    fix_hold = 50;
    push_byte(8'hAA); push_byte(8'hBB); push_byte(8'hCC);
    tx_enable = 1'b1;
    k = 0;
    while (Tx_BUSY !== 1'b1 && k < 20) begin tick(); k++; end
    check("rst_busy_seen", 32'(k < 20), 32'd1);
    repeat (2) tick();
    check("rst_pre_feeder_busy", 32'(feeder_busy), 32'd1);
    check("rst_pre_count", 32'(count), 32'd3);
    #2 reset = 1'b0;
    #1 check_reset_values("mid_reset");
    repeat (2) tick();
    reset = 1'b1;
    fix_hold = 3;
    base = log_q.size();
    repeat (30) tick();
    check("post_reset_no_wr", 32'(log_q.size() - base), 32'd0);
    check("post_reset_empty", 32'(empty), 32'd1);

    // Randomized traffic, transmitter with random latency and dropped pulses.
    rand_mode = 1'b1;
    repeat (700) begin
      wr_en     = ($urandom_range(0, 2) == 0);
      wr_data   = 8'($urandom);
      tx_enable = ($urandom_range(0, 9) != 0);
      tick();
    end
    wr_en = 1'b0;
    tx_enable = 1'b1;
    wait_idle(600, "random_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
